// File: rtl/sound_sdr_pkg.sv
// Shared types and helpers for the sound-subsystem SDRAM arbiter.
// Holds the FSM state encoding, the read byte-enable code and the 16-bit lane picker.
package sound_sdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CPU,
    WAIT_SMP
  } state_t;

  localparam logic [1:0] RD_SEL = 2'b00;

  // Pick the 16-bit lane of a 64-bit SDRAM burst addressed by addr[2:1].
  function automatic logic [15:0] word_sel(input logic [1:0] sel, input logic [63:0] data);
    logic [15:0] w;
    case (sel)
      2'd0:    w = data[15:0];
      2'd1:    w = data[31:16];
      2'd2:    w = data[47:32];
      default: w = data[63:48];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sound_sdr_arb.sv
// Two-port toggle-handshake SDRAM arbiter: V35 CPU port (16-bit r/w) and GA20
// sample port (64-bit read) share one downstream SDRAM slot.
module sound_sdr_arb
  import sound_sdr_pkg::*;
#(
  parameter int MAX_CPU_RUN = 4,
  parameter int AW          = 25
) (
  input  logic          clk_sys,
  input  logic          reset,

  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_din,
  input  logic [1:0]    cpu_wr_sel,
  input  logic          cpu_req,
  output logic          cpu_ack,
  output logic [15:0]   cpu_dout,

  input  logic [AW-1:0] smp_addr,
  input  logic          smp_req,
  output logic          smp_ack,
  output logic [63:0]   smp_data,

  output logic [AW-1:0] sdr_addr,
  output logic [15:0]   sdr_din,
  output logic [1:0]    sdr_wr_sel,
  output logic          sdr_req,
  input  logic          sdr_ack,
  input  logic [63:0]   sdr_dout,

  output logic          busy
);

  localparam int RUN_W = (MAX_CPU_RUN < 1) ? 1 : $clog2(MAX_CPU_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

  state_t           state;
  logic [RUN_W-1:0] run_cnt;

  logic cpu_pend;
  logic smp_pend;
  logic smp_turn;
  logic grant_smp;
  logic grant_cpu;
  logic sdr_idle;

  assign cpu_pend  = (cpu_req != cpu_ack);
  assign smp_pend  = (smp_req != smp_ack);
  assign sdr_idle  = (sdr_req == sdr_ack);

  // Starvation guard: after MAX_CPU_RUN back-to-back CPU wins the sample port takes a turn.
  assign smp_turn  = (MAX_CPU_RUN != 0) && (run_cnt == RUN_MAX);
  assign grant_smp = smp_pend && (!cpu_pend || smp_turn);
  assign grant_cpu = cpu_pend && !grant_smp;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      run_cnt    <= '0;
      busy       <= 1'b0;
      cpu_ack    <= 1'b0;
      smp_ack    <= 1'b0;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      sdr_wr_sel <= RD_SEL;
      cpu_dout   <= '0;
      smp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!smp_pend) run_cnt <= '0;
          // Hold off while the controller still owes an ack (e.g. after a mid-transaction reset).
          if (sdr_idle) begin
            if (grant_cpu) begin
              sdr_addr   <= cpu_addr;
              sdr_din    <= cpu_din;
              sdr_wr_sel <= cpu_wr_sel;
              sdr_req    <= ~sdr_req;
              busy       <= 1'b1;
              state      <= WAIT_CPU;
              if (smp_pend && (run_cnt != RUN_MAX)) run_cnt <= run_cnt + RUN_W'(1);
            end else if (grant_smp) begin
              sdr_addr   <= smp_addr;
              sdr_din    <= '0;
              sdr_wr_sel <= RD_SEL;
              sdr_req    <= ~sdr_req;
              busy       <= 1'b1;
              run_cnt    <= '0;
              state      <= WAIT_SMP;
            end
          end
        end

        WAIT_CPU: begin
          if (sdr_idle) begin
            cpu_dout <= word_sel(sdr_addr[2:1], sdr_dout);
            cpu_ack  <= ~cpu_ack;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        WAIT_SMP: begin
          if (sdr_idle) begin
            smp_data <= sdr_dout;
            smp_ack  <= ~smp_ack;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_sdr_arb.sv
// Scoreboard bench for sound_sdr_arb: directed requests, a toy SDRAM responder,
// and a negedge monitor that checks every grant and every requester ack.
`timescale 1ns/100ps
module tb_sound_sdr_arb;

  localparam int AW = 25;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [1:0]    wr_sel;
  } grant_t;

  typedef struct {
    logic        chk;
    logic [63:0] data;
  } rsp_t;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_din;
  logic [1:0]    cpu_wr_sel;
  logic          cpu_req;
  logic          cpu_ack;
  logic [15:0]   cpu_dout;
  logic [AW-1:0] smp_addr;
  logic          smp_req;
  logic          smp_ack;
  logic [63:0]   smp_data;
  logic [AW-1:0] sdr_addr;
  logic [15:0]   sdr_din;
  logic [1:0]    sdr_wr_sel;
  logic          sdr_req;
  logic          sdr_ack;
  logic [63:0]   sdr_dout;
  logic          busy;

  logic [63:0]   resp_data;
  logic          ack_hold;
  logic          ack_hold_val;

  grant_t grant_q[$];
  rsp_t   cpu_q[$];
  rsp_t   smp_q[$];

  int checks = 0;
  int errors = 0;

  sound_sdr_arb #(.MAX_CPU_RUN(4), .AW(AW)) u_dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_wr_sel (cpu_wr_sel),
    .cpu_req    (cpu_req),
    .cpu_ack    (cpu_ack),
    .cpu_dout   (cpu_dout),
    .smp_addr   (smp_addr),
    .smp_req    (smp_req),
    .smp_ack    (smp_ack),
    .smp_data   (smp_data),
    .sdr_addr   (sdr_addr),
    .sdr_din    (sdr_din),
    .sdr_wr_sel (sdr_wr_sel),
    .sdr_req    (sdr_req),
    .sdr_ack    (sdr_ack),
    .sdr_dout   (sdr_dout),
    .busy       (busy)
  );

  always #12.5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_grant(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] ws);
    grant_t g;
    g.addr = a; g.din = d; g.wr_sel = ws;
    grant_q.push_back(g);
  endtask

  task automatic push_cpu(input logic chk, input logic [15:0] d);
    rsp_t r;
    r.chk = chk; r.data = {48'h0, d};
    cpu_q.push_back(r);
  endtask

  task automatic push_smp(input logic [63:0] d);
    rsp_t r;
    r.chk = 1'b1; r.data = d;
    smp_q.push_back(r);
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while ((grant_q.size() != 0 || cpu_q.size() != 0 || smp_q.size() != 0 || busy) && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL wait_done timeout actual=%0d required<%0d", n, max_cyc);
    end
    repeat (2) tick();
  endtask

  // Toy SDRAM controller: answers each request two cycles after it appears.
  initial begin
    int lat = 0;
    sdr_ack  = 1'b0;
    sdr_dout = '0;
    forever begin
      @(posedge clk_sys);
      #2;
      if (ack_hold) begin
        sdr_ack = ack_hold_val;
        lat = 0;
      end else if (sdr_req != sdr_ack) begin
        if (lat >= 2) begin
          sdr_dout = resp_data;
          sdr_ack  = sdr_req;
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // Monitor: every sdr_req toggle is a grant, every ack toggle a completion.
  initial begin
    int cyc = 0;
    int last_ack_cyc = -10;
    logic p_sdr_req, p_sdr_ack, p_cpu_ack, p_smp_ack, p_busy;
    grant_t g;
    rsp_t   r;
    p_sdr_req = 0; p_sdr_ack = 0; p_cpu_ack = 0; p_smp_ack = 0; p_busy = 0;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (!reset) begin
        if (sdr_ack != p_sdr_ack) last_ack_cyc = cyc;
        if (sdr_req != p_sdr_req) begin
          if (grant_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant actual=%0h required=none", sdr_addr);
          end else begin
            g = grant_q.pop_front();
            check("grant_addr", {39'h0, sdr_addr}, {39'h0, g.addr});
            check("grant_din", {48'h0, sdr_din}, {48'h0, g.din});
            check("grant_wr_sel", {62'h0, sdr_wr_sel}, {62'h0, g.wr_sel});
            check("grant_busy_edge", {62'h0, p_busy, busy}, 64'h1);
          end
        end
        if (cpu_ack != p_cpu_ack) begin
          check("cpu_ack_latency", 64'(cyc - last_ack_cyc), 64'd1);
          if (cpu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cpu_ack actual=%0h required=none", cpu_ack);
          end else begin
            r = cpu_q.pop_front();
            if (r.chk) check("cpu_dout", {48'h0, cpu_dout}, r.data);
          end
        end
        if (smp_ack != p_smp_ack) begin
          check("smp_ack_latency", 64'(cyc - last_ack_cyc), 64'd1);
          if (smp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_smp_ack actual=%0h required=none", smp_ack);
          end else begin
            r = smp_q.pop_front();
            check("smp_data", smp_data, r.data);
          end
        end
      end
      p_sdr_req = sdr_req; p_sdr_ack = sdr_ack;
      p_cpu_ack = cpu_ack; p_smp_ack = smp_ack; p_busy = busy;
    end
  end

  initial begin
    logic old_req;
    int n;
    logic [AW-1:0] ca[6];
    logic [15:0]   cw[6];
    ca = '{25'h000200, 25'h000202, 25'h000204, 25'h000206, 25'h000208, 25'h00020A};
    cw = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 16'h2222};

    reset = 1'b1;
    cpu_addr = '0; cpu_din = '0; cpu_wr_sel = 2'b00; cpu_req = 1'b0;
    smp_addr = '0; smp_req = 1'b0;
    resp_data = '0; ack_hold = 1'b0; ack_hold_val = 1'b0;
    repeat (3) tick();

    check("rst_cpu_ack", {63'h0, cpu_ack}, 64'h0);
    check("rst_smp_ack", {63'h0, smp_ack}, 64'h0);
    check("rst_sdr_req", {63'h0, sdr_req}, 64'h0);
    check("rst_sdr_addr", {39'h0, sdr_addr}, 64'h0);
    check("rst_sdr_din", {48'h0, sdr_din}, 64'h0);
    check("rst_sdr_wr_sel", {62'h0, sdr_wr_sel}, 64'h0);
    check("rst_cpu_dout", {48'h0, cpu_dout}, 64'h0);
    check("rst_smp_data", smp_data, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    reset = 1'b0;
    repeat (2) tick();

    // CPU read alone, lane 3
    resp_data  = 64'h4444_3333_2222_1111;
    cpu_addr   = 25'h0A0006;
    cpu_wr_sel = 2'b00;
    push_grant(25'h0A0006, 16'h0000, 2'b00);
    push_cpu(1'b1, 16'h4444);
    old_req = sdr_req;
    cpu_req = ~cpu_req;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("cpu_rd_req_latency", {63'h0, sdr_req}, {63'h0, ~old_req});
    check("cpu_rd_busy", {63'h0, busy}, 64'h1);
    wait_done(50);

    // CPU write, upper byte
    cpu_addr   = 25'h0A0010;
    cpu_din    = 16'hAB00;
    cpu_wr_sel = 2'b10;
    push_grant(25'h0A0010, 16'hAB00, 2'b10);
    push_cpu(1'b0, 16'h0000);
    cpu_req = ~cpu_req;
    wait_done(50);

    // Sample alone; stale CPU write data must not leak onto sdr_din
    resp_data = 64'h8877_6655_4433_2211;
    smp_addr  = 25'h100008;
    push_grant(25'h100008, 16'h0000, 2'b00);
    push_smp(64'h8877_6655_4433_2211);
    smp_req = ~smp_req;
    wait_done(50);

    // Contention: simultaneous start, CPU re-requests at once after every ack
    resp_data  = 64'h4444_3333_2222_1111;
    cpu_wr_sel = 2'b00;
    cpu_din    = 16'h0000;
    smp_addr   = 25'h180000;
    for (int i = 0; i < 4; i++) push_grant(ca[i], 16'h0, 2'b00);
    push_grant(25'h180000, 16'h0, 2'b00);
    for (int i = 4; i < 6; i++) push_grant(ca[i], 16'h0, 2'b00);
    for (int i = 0; i < 6; i++) push_cpu(1'b1, cw[i]);
    push_smp(64'h4444_3333_2222_1111);
    smp_req = ~smp_req;
    for (int i = 0; i < 6; i++) begin
      cpu_addr = ca[i];
      cpu_req  = ~cpu_req;
      n = 0;
      while (cpu_ack !== cpu_req && n < 200) begin
        tick();
        n++;
      end
      checks++;
      if (n >= 200) begin
        errors++;
        $display("FAIL contention_cpu_ack timeout actual=%0d required<200", n);
      end
    end
    wait_done(100);

    // Reset while waiting on a sample read, then controller ack left mismatched
    ack_hold_val = sdr_ack;
    ack_hold     = 1'b1;
    smp_addr     = 25'h100100;
    push_grant(25'h100100, 16'h0, 2'b00);
    smp_req = ~smp_req;
    repeat (4) tick();
    check("rst_mid_busy", {63'h0, busy}, 64'h1);
    reset        = 1'b1;
    cpu_req      = 1'b0;
    ack_hold_val = 1'b1;
    repeat (2) tick();
    reset    = 1'b0;
    smp_addr = 25'h100200;
    repeat (6) tick();
    check("stall_sdr_req", {63'h0, sdr_req}, 64'h0);
    check("stall_busy", {63'h0, busy}, 64'h0);
    check("stall_smp_ack", {63'h0, smp_ack}, 64'h0);
    check("stall_cpu_ack", {63'h0, cpu_ack}, 64'h0);
    resp_data = 64'hDEAD_BEEF_0123_4567;
    push_grant(25'h100200, 16'h0, 2'b00);
    push_smp(64'hDEAD_BEEF_0123_4567);
    ack_hold_val = 1'b0;
    tick();
    ack_hold = 1'b0;
    wait_done(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_sdr_arb.md
Name: sound_sdr_arb

Overview:
- Shares one toggle-handshake SDRAM channel between two requesters in the M107 sound subsystem: the V35 program/RAM port (16-bit read/write) and the GA20 sample-ROM fetch port (64-bit read).
- Arbitrates between the two ports, latches the winning request, issues it downstream and returns data plus a toggled ack to the winner.
- Sits between the sound module and the top-level SDRAM controller, so that sound needs one SDRAM slot instead of two.

Parameters:
- MAX_CPU_RUN, 4: maximum consecutive CPU grants while a sample request is pending. 0 = fixed CPU priority, no starvation guard.
- AW, 25: SDRAM address width.

Ports:
- clk_sys  in  1  system clock, 40 MHz
- reset  in  1  asynchronous, active-high
- cpu_addr  in  AW  CPU byte address
- cpu_din  in  16  CPU write data
- cpu_wr_sel  in  2  byte enables; 00 = read
- cpu_req  in  1  toggle request
- cpu_ack  out  1  toggle ack
- cpu_dout  out  16  CPU read word
- smp_addr  in  AW  sample byte address
- smp_req  in  1  toggle request
- smp_ack  out  1  toggle ack
- smp_data  out  64  sample read data
- sdr_addr  out  AW  downstream address
- sdr_din  out  16  downstream write data
- sdr_wr_sel  out  2  downstream byte enables
- sdr_req  out  1  downstream toggle request
- sdr_ack  in  1  downstream toggle ack
- sdr_dout  in  64  downstream read data, aligned to addr[2:0]=0
- busy  out  1  high while a downstream transaction is outstanding

Behaviour:
- Reset values:
  - cpu_ack, smp_ack, sdr_req = 0.
  - sdr_addr, sdr_din, sdr_wr_sel, cpu_dout, smp_data = 0.
  - busy = 0; run counter = 0; state = IDLE.
- Pending flags: cpu_pend = (cpu_req != cpu_ack); smp_pend = (smp_req != smp_ack).
- States:
  - IDLE: acts only when sdr_req == sdr_ack. Selects a winner:
    - only one pending: that port wins.
    - both pending: CPU wins unless MAX_CPU_RUN != 0 and run counter == MAX_CPU_RUN, in which case the sample port wins.
    - On a grant, at the same edge: latch addr/din/wr_sel into the sdr_* outputs, toggle sdr_req, set busy = 1, go to WAIT_CPU or WAIT_SMP.
    - Sample grants always drive sdr_wr_sel = 00 and sdr_din = 0.
  - WAIT_CPU: at the edge where sdr_ack == sdr_req:
    - cpu_dout <= sdr_dout word selected by sdr_addr[2:1] (0 -> [15:0], 1 -> [31:16], 2 -> [47:32], 3 -> [63:48]). cpu_dout is updated for writes too, with don't-care content.
    - Toggle cpu_ack, busy = 0, return to IDLE.
  - WAIT_SMP: at the edge where sdr_ack == sdr_req: smp_data <= sdr_dout, toggle smp_ack, busy = 0, return to IDLE.
- Latency:
  - From a pending request seen in IDLE to the sdr_req toggle: 1 clk.
  - From sdr_ack matching to the requester ack toggle: 1 clk.
  - Minimum gap between back-to-back grants: 1 IDLE clk.
- Run counter:
  - Increments on a CPU grant made while smp_pend = 1, saturating at MAX_CPU_RUN.
  - Clears on any sample grant, and in any IDLE cycle where smp_pend = 0.
- Requester inputs are sampled only at grant. A requester may change addr/data after its grant but must not toggle req again before its ack.
- A request toggled while its port is in service is illegal (the previous ack is still outstanding). It is not detected.
- Simultaneous events:
  - Both requests becoming pending in the same cycle are resolved by the priority rule.
  - A new request arriving on the same edge that completes the other port's transaction is granted in the next IDLE cycle.
- Reset mid-transaction: the transaction is abandoned and no ack is toggled. The SDRAM controller shares this reset.
  - If sdr_ack != sdr_req after reset release, IDLE stalls until they match. No spurious grant is issued.
- Requester reqs are not reset here. A mismatch at reset release is served as a real pending request.

Decomposition:
- Package sound_sdr_pkg holds:
  - typedef enum of states {IDLE, WAIT_CPU, WAIT_SMP}.
  - constant RD_SEL = 2'b00.
  - function word_sel(addr[2:1], data64) returning 16 bits.
- No sub-module. The arbiter is a single FSM plus counter.

Test Plan:
- CPU read alone: cpu_addr=0x0A0006, req toggled, sdr_dout=0x4444_3333_2222_1111 -> sdr_addr=0x0A0006 and sdr_wr_sel=00 one clk later; cpu_dout=0x4444, cpu_ack toggles one clk after sdr_ack.
- CPU write: cpu_wr_sel=10, cpu_din=0xAB00 -> sdr_wr_sel=10, sdr_din=0xAB00, single sdr_req toggle, cpu_ack toggles after sdr_ack.
- Sample alone: smp_addr=0x100008 -> smp_data equals sdr_dout exactly, sdr_wr_sel=00, smp_ack toggles.
- Contention with MAX_CPU_RUN=4: CPU re-requests immediately after every ack while a sample is pending -> grant order CPU,CPU,CPU,CPU,SMP,CPU…; with MAX_CPU_RUN=0 the sample waits until the CPU goes idle.
- Simultaneous first requests with run counter 0 -> CPU is granted first and the sample next; no grant is issued while busy=1.
- Reset asserted in WAIT_SMP, then sdr_ack held at 1 after release -> no grant and no acks until sdr_ack returns to 0; afterwards the pending sample is served normally.
